// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: shift operation select and burst FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_reg_pkg;

    // Width of the operation-select field.
    localparam int MODE_W = 3;

    // Operation select; encodings 6 and 7 are reserved and behave as HOLD.
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHR   = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_ASR   = 3'd3,
        MODE_ROR   = 3'd4,
        MODE_ROL   = 3'd5,
        MODE_RSVD6 = 3'd6,
        MODE_RSVD7 = 3'd7
    } shift_mode_t;

    // Burst controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/shift_step.sv
// One shift step: next register value and the bit leaving it, for a given operation.
// Latency: combinational. Rotates exist only when SHIFT_REG_ROTATE_EN is defined.
// Backpressure: none; shifted_o flags whether the operation actually moved bits.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  shift_mode_t      mode_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_bit_o,
    output logic             shifted_o
);

    // Select the shifted value; HOLD-like encodings pass q through and report no shift.
    always_comb begin
        q_o       = q_i;
        out_bit_o = 1'b0;
        shifted_o = 1'b0;
        case (mode_i)
            MODE_SHR: begin
                q_o       = {ser_in_i, q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
                shifted_o = 1'b1;
            end
            MODE_SHL: begin
                q_o       = {q_i[WIDTH-2:0], ser_in_i};
                out_bit_o = q_i[WIDTH-1];
                shifted_o = 1'b1;
            end
            MODE_ASR: begin
                q_o       = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
                shifted_o = 1'b1;
            end
`ifdef SHIFT_REG_ROTATE_EN
            MODE_ROR: begin
                q_o       = {q_i[0], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
                shifted_o = 1'b1;
            end
            MODE_ROL: begin
                q_o       = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_bit_o = q_i[WIDTH-1];
                shifted_o = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, single-step shifts and counted burst shifts.
// Latency: one clk per shift; burst of N takes N busy cycles then one done cycle. Optional SHIFT_REG_ROTATE_EN adds ROR/ROL.
// Backpressure: start/ena ignored while busy; load always wins and aborts a burst without done.
module universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic [MODE_W-1:0] mode,
    input  logic              ser_in,
    input  logic              ena,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    fsm_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_out_q, ser_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    shift_mode_t      mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    shift_mode_t      step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic             step_shifted;

    // A burst uses the mode captured at start; otherwise the live mode input drives the step.
    assign step_mode = (state_q == ST_SHIFT) ? mode_q : shift_mode_t'(mode);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i       (q_q),
        .mode_i    (step_mode),
        .ser_in_i  (ser_in),
        .q_o       (step_q),
        .out_bit_o (step_bit),
        .shifted_o (step_shifted)
    );

    // Next-state decision in priority order: load, running burst, burst start, single step.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        ser_out_d = ser_out_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        if (load) begin
            q_d     = data;
            state_d = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
            q_d = step_q;
            if (step_shifted) begin
                ser_out_d = step_bit;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_DONE;
            end
        end else if (start) begin
            if (count != '0) begin
                state_d = ST_SHIFT;
                mode_d  = shift_mode_t'(mode);
                cnt_d   = count;
            end else begin
                state_d = ST_DONE;
            end
        end else begin
            state_d = ST_IDLE;
            if (ena) begin
                q_d = step_q;
                if (step_shifted) begin
                    ser_out_d = step_bit;
                end
            end
        end
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // All state, including the registered busy/done flags, updates here.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= ST_IDLE;
            q_q       <= '0;
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= MODE_HOLD;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg at WIDTH=8: directed scenarios then random traffic vs a reference model.
// Latency: model advances once per rising clk edge; outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_universal_shift_reg;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int MSB   = 1 << (W - 1);
    localparam int RANGE = 1 << W;

    logic          clk = 1'b0;
    logic          areset_n;
    logic          load;
    logic [W-1:0]  data;
    logic [2:0]    mode;
    logic          ser_in;
    logic          ena;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register value, last bit out, shifts remaining in a burst.
    int unsigned mq;
    int unsigned mser;
    int          rem;
    int          bmode;
    int unsigned mdone;

    universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (load),
        .data     (data),
        .mode     (mode),
        .ser_in   (ser_in),
        .ena      (ena),
        .start    (start),
        .count    (count),
        .q        (q),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One shift of the model register, described arithmetically.
    task automatic m_shift(input int md, input int unsigned si);
        int unsigned outb;
        bit          moved;
        moved = 1'b1;
        outb  = 0;
        case (md)
            1: begin outb = mq % 2;   mq = mq / 2 + si * MSB; end
            2: begin outb = mq / MSB; mq = (mq * 2) % RANGE + si; end
            3: begin outb = mq % 2;   mq = mq / 2 + ((mq >= MSB) ? MSB : 0); end
`ifdef SHIFT_REG_ROTATE_EN
            4: begin outb = mq % 2;   mq = mq / 2 + (mq % 2) * MSB; end
            5: begin outb = mq / MSB; mq = (mq * 2) % RANGE + mq / MSB; end
`endif
            default: moved = 1'b0;
        endcase
        if (moved) mser = outb;
    endtask

    task automatic m_reset();
        mq = 0; mser = 0; rem = 0; bmode = 0; mdone = 0;
    endtask

    // Effect of one rising edge given the current inputs.
    task automatic m_edge();
        mdone = 0;
        if (load) begin
            mq  = data;
            rem = 0;
        end else if (rem > 0) begin
            m_shift(bmode, ser_in);
            rem--;
            if (rem == 0) mdone = 1;
        end else if (start) begin
            bmode = mode;
            rem   = count;
            if (count == 0) mdone = 1;
        end else if (ena) begin
            m_shift(mode, ser_in);
        end
    endtask

    task automatic chk_all();
        chk("q", q, mq);
        chk("ser_out", ser_out, mser);
        chk("busy", busy, (rem > 0) ? 1 : 0);
        chk("done", done, mdone);
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk_all();
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; ena = 0;
    endtask

    initial begin
        areset_n = 1; load = 0; data = '0; mode = 0; ser_in = 0;
        ena = 0; start = 0; count = '0;
        m_reset();
        #3 areset_n = 0;
        #1;
        chk_all();
        @(negedge clk);
        @(negedge clk);
        areset_n = 1;

        // Scenario 1: single SHR step
        load = 1; data = 8'hA5; tick();
        load = 0; mode = 1; ser_in = 0; ena = 1; tick();
        ena = 0;
        chk("s1_q", q, 8'h52);
        chk("s1_ser", ser_out, 1);

        // Scenario 2: ASR burst of 3
        load = 1; data = 8'h80; tick();
        load = 0; start = 1; mode = 3; count = 3; tick();
        start = 0; mode = 0; count = 0;
        chk("s2_busy0", busy, 1);
        tick(); chk("s2_c0", q, 8'hC0); chk("s2_busy1", busy, 1);
        tick(); chk("s2_e0", q, 8'hE0); chk("s2_busy2", busy, 1);
        tick(); chk("s2_f0", q, 8'hF0); chk("s2_busy3", busy, 0); chk("s2_done", done, 1);
        tick(); chk("s2_done_end", done, 0);

        // Scenario 3: ROL step
        load = 1; data = 8'h81; tick();
        load = 0; mode = 5; ena = 1; tick();
        ena = 0;
`ifdef SHIFT_REG_ROTATE_EN
        chk("s3_q", q, 8'h03);
        chk("s3_ser", ser_out, 1);
`else
        chk("s3_q", q, 8'h81);
`endif

        // Scenario 4: SHL burst aborted by load on the second busy cycle
        load = 1; data = 8'h01; tick();
        load = 0; start = 1; mode = 2; count = 5; ser_in = 0; tick();
        start = 0;
        tick();
        chk("s4_busy2", busy, 1);
        load = 1; data = 8'h3C; tick();
        load = 0;
        chk("s4_q", q, 8'h3C); chk("s4_busy", busy, 0); chk("s4_done", done, 0);
        tick(); chk("s4_done2", done, 0);

        // Scenario 5: zero-length burst
        start = 1; count = 0; mode = 1; tick();
        start = 0;
        chk("s5_done", done, 1); chk("s5_busy", busy, 0); chk("s5_q", q, 8'h3C);
        tick(); chk("s5_done2", done, 0);

        // Start+ena together, mode/count changes and start/ena while busy, count > WIDTH
        load = 1; data = 8'h5A; tick();
        load = 0; start = 1; ena = 1; mode = 1; ser_in = 1; count = 12; tick();
        for (int i = 0; i < 14; i++) begin
            start = i[0]; ena = 1; mode = 3'(i); count = 4'(i); ser_in = i[1];
            tick();
        end
        idle_inputs();
        tick();

        // Scenario 6: asynchronous reset mid-burst, then a new burst
        load = 1; data = 8'hF3; tick();
        load = 0; start = 1; mode = 1; ser_in = 1; count = 6; tick();
        start = 0; tick();
        #2 areset_n = 0;
        #1;
        m_reset();
        chk("s6_q", q, 0); chk("s6_busy", busy, 0);
        chk("s6_done", done, 0); chk("s6_ser", ser_out, 0);
        @(posedge clk); #1; chk_all();
        @(negedge clk) areset_n = 1;
        load = 1; data = 8'h96; tick();
        load = 0; start = 1; mode = 2; ser_in = 0; count = 2; tick();
        start = 0;
        tick(); tick();
        chk("s6_after_q", q, 8'h58); chk("s6_after_done", done, 1);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            load   = ($urandom_range(0, 9) == 0);
            data   = W'($urandom_range(0, RANGE - 1));
            start  = ($urandom_range(0, 5) == 0);
            ena    = $urandom_range(0, 1) != 0;
            mode   = 3'($urandom_range(0, 7));
            count  = CW'($urandom_range(0, (1 << CW) - 1));
            ser_in = $urandom_range(0, 1) != 0;
            tick();
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the burst shift-count input.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port areset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load  input  1  parallel load request.
REQ-006 The block SHALL have port data  input  WIDTH  parallel load value.
REQ-007 The block SHALL have port mode  input  3  shift operation select (shift_mode_t).
REQ-008 The block SHALL have port ser_in  input  1  fill bit for logical shifts.
REQ-009 The block SHALL have port ena  input  1  single-step shift request.
REQ-010 The block SHALL have port start  input  1  burst shift request.
REQ-011 The block SHALL have port count  input  CNT_W  number of shifts in a burst.
REQ-012 The block SHALL have port q  output  WIDTH  register contents.
REQ-013 The block SHALL have port ser_out  output  1  registered last bit shifted out.
REQ-014 The block SHALL have port busy  output  1  high while a burst is executing.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 Mode encodings SHALL be: 0 HOLD; 1 SHR, q <= {ser_in, q[W-1:1]}; 2 SHL, q <= {q[W-2:0], ser_in}; 3 ASR, q <= {q[W-1], q[W-1:1]}; 4 ROR; 5 ROL; 6-7 HOLD.
REQ-017 On every shift, ser_out SHALL load the bit leaving the register: q[0] for SHR/ASR/ROR and q[W-1] for SHL/ROL; HOLD leaves ser_out unchanged.
REQ-018 Per-cycle priority SHALL be load, then burst activity, then ena.
REQ-019 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-020 In IDLE or DONE, start with count > 0 SHALL latch mode and count and enter SHIFT.
REQ-021 In IDLE or DONE, start with count == 0 SHALL enter DONE with q unchanged.
REQ-022 In SHIFT, the block SHALL perform exactly one shift of the latched mode per cycle, for the latched count cycles, then enter DONE.
REQ-023 busy SHALL be high exactly during SHIFT cycles.
REQ-024 done SHALL be high exactly during the single DONE cycle.
REQ-025 DONE SHALL return to IDLE unless start is accepted in that cycle.
REQ-026 start and ena SHALL be ignored while busy.
REQ-027 mode and count changes during SHIFT SHALL have no effect.
REQ-028 ena with no load, no accepted start and not busy SHALL perform one shift of the current mode in that cycle.
REQ-029 Simultaneous start and ena outside SHIFT SHALL start the burst; ena SHALL not add an extra shift.
REQ-030 load during SHIFT SHALL abort the burst: q <= data, go to IDLE, no done pulse.
REQ-031 load together with an accepted start SHALL perform the load and drop the start.
REQ-032 count values larger than WIDTH SHALL be executed literally, with no clamping.

Reset
REQ-033 areset_n low SHALL immediately force q = 0, ser_out = 0, busy = 0, done = 0 and state IDLE, including mid-burst.
REQ-034 Operation SHALL resume on the first clk edge after areset_n deasserts.

Configuration
REQ-035 With SHIFT_REG_ROTATE_EN defined, ROR SHALL implement q <= {q[0], q[W-1:1]} and ROL SHALL implement q <= {q[W-2:0], q[W-1]}.
REQ-036 Without SHIFT_REG_ROTATE_EN, encodings 4 and 5 SHALL behave as HOLD, and rotate logic SHALL be absent.

Structure
REQ-037 Package shift_reg_pkg SHALL hold shift_mode_t (3-bit enum), the FSM state enum and the mode constants.
REQ-038 A combinational sub-module shift_step SHALL compute the next q and the out-bit from (q, mode, ser_in); it is shared by single-step and burst paths.

Verification (WIDTH=8)
REQ-039 Scenario 1: load 8'hA5, then mode=SHR, ser_in=0, ena one cycle -> q=8'h52, ser_out=1.
REQ-040 Scenario 2: load 8'h80, then start, mode=ASR, count=3 -> busy for 3 cycles, q steps 8'hC0, 8'hE0, 8'hF0, then done for 1 cycle.
REQ-041 Scenario 3: load 8'h81, then ROL with ena -> q=8'h03 and ser_out=1 with macro; q=8'h81 without macro.
REQ-042 Scenario 4: burst SHL count=5 from 8'h01, load 8'h3C on the 2nd busy cycle -> q=8'h3C, busy=0 next cycle, done never asserted.
REQ-043 Scenario 5: start with count=0 -> done=1 next cycle, busy never high, q unchanged.
REQ-044 Scenario 6: areset_n low during a burst -> q=0, busy=0, done=0 and ser_out=0 without waiting for clk; a new start after release works normally.
